// File: rtl/mitll_dfft_arb_seq.sv
// Round-robin arbiter and access sequencer for one shared mitll_dfft cell.
// Optional protocol checker enabled by defining MITLL_DFFT_SEQ_ERRCHK_EN.
module mitll_dfft_arb_seq #(
  parameter int NREQ      = 4,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_bit,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            done,
  output logic            result,
  output logic            dfft_in,
  output logic            dfft_clk,
  input  logic            dfft_out,
  output logic            err
);

  localparam int PW      = $clog2(NREQ);
  localparam int CNT_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_SETUP, S_CLOCK, S_HOLD, S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic            bit_q, bit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cap_q, cap_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            result_q, result_d;
  logic            dfft_in_q, dfft_in_d;
  logic            dfft_clk_q, dfft_clk_d;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW:0]     scan_idx;

  // Rotating priority search: first set request at or after ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = {1'b0, ptr_q} + (PW+1)'(i);
      if (scan_idx >= (PW+1)'(NREQ))
        scan_idx = scan_idx - (PW+1)'(NREQ);
      if (!pick_found && req[scan_idx[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          win_d   = pick_idx;
          bit_d   = req_bit[pick_idx];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_d   = CW'(SETUP_CYC - 1);
        state_d = S_SETUP;
      end
      S_SETUP: begin
        if (cnt_q == '0) state_d = S_CLOCK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CLOCK: begin
        cap_d   = dfft_out;
        cnt_d   = CW'(HOLD_CYC - 1);
        state_d = S_HOLD;
      end
      S_HOLD: begin
        cap_d = cap_q | dfft_out;
        if (cnt_q == '0) begin
          // Include the last hold cycle's sample in the returned bit.
          result_d = cap_q | dfft_out;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_RESP);
    dfft_in_d  = (state_d == S_DATA) && bit_d;
    dfft_clk_d = (state_d == S_CLOCK);
    gnt_d      = '0;
    if (busy_d) gnt_d[win_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      bit_q      <= 1'b0;
      cnt_q      <= '0;
      cap_q      <= 1'b0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 1'b0;
      dfft_in_q  <= 1'b0;
      dfft_clk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      dfft_in_q  <= dfft_in_d;
      dfft_clk_q <= dfft_clk_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign dfft_in  = dfft_in_q;
  assign dfft_clk = dfft_clk_q;

`ifdef MITLL_DFFT_SEQ_ERRCHK_EN
  logic err_q, err_d;
  logic prev_q, prev_d;
  logic in_win;

  // dfft_out is only legal as a single-cycle pulse inside CLOCK/HOLD.
  always_comb begin
    in_win = (state_q == S_CLOCK) || (state_q == S_HOLD);
    prev_d = in_win && dfft_out;
    err_d  = err_q | (dfft_out && (!in_win || prev_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      prev_q <= prev_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
